// File: rtl/ps2_kbd_pkg.sv
// Shared constants for the PS/2 set-2 scancode decoder: scancodes, FSM states, modifier bits.
package ps2_kbd_pkg;

    localparam logic [7:0] SC_EXT      = 8'hE0;
    localparam logic [7:0] SC_BRK      = 8'hF0;
    localparam logic [7:0] SC_LSHIFT   = 8'h12;
    localparam logic [7:0] SC_RSHIFT   = 8'h59;
    localparam logic [7:0] SC_CTRL     = 8'h14;
    localparam logic [7:0] SC_CAPS     = 8'h58;
    localparam logic [7:0] SC_BAT      = 8'hAA;
    localparam logic [7:0] SC_ACK      = 8'hFA;
    localparam logic [7:0] SC_ECHO     = 8'hEE;
    localparam logic [7:0] SC_RESEND   = 8'hFE;
    localparam logic [7:0] SC_ERR0     = 8'h00;
    localparam logic [7:0] SC_ERR1     = 8'hFF;
    localparam logic [7:0] SC_KP_SLASH = 8'h4A;
    localparam logic [7:0] SC_ENTER    = 8'h5A;
    localparam logic [7:0] SC_BKSP     = 8'h66;
    localparam logic [7:0] SC_ESC      = 8'h76;

    localparam int unsigned MOD_SHIFT = 0;
    localparam int unsigned MOD_CTRL  = 1;
    localparam int unsigned MOD_CAPS  = 2;

    typedef enum logic {StIdle, StDecode} state_e;

    // Controller chatter (BAT, ACK, echo, resend, overrun) that never forms a key event.
    function automatic logic is_discard(input logic [7:0] b);
        return (b == SC_BAT) || (b == SC_ACK) || (b == SC_ECHO) || (b == SC_RESEND) ||
               (b == SC_ERR0) || (b == SC_ERR1);
    endfunction

endpackage

// File: rtl/ps2_scancode_decoder_if.sv
// Receiver-FIFO pop port plus key-event valid/ready port of the scancode decoder.
interface ps2_scancode_decoder_if;
    logic [7:0] kbd_data;
    logic       kbd_ready;
    logic       kbd_read_enable;
    logic       evt_valid;
    logic       evt_ready;
    logic [7:0] evt_code;
    logic       evt_ext;
    logic       evt_release;
    logic [7:0] evt_ascii;
    logic [2:0] evt_mods;

    modport master (
        input  kbd_data, kbd_ready, evt_ready,
        output kbd_read_enable, evt_valid, evt_code, evt_ext, evt_release, evt_ascii, evt_mods
    );

    modport slave (
        output kbd_data, kbd_ready, evt_ready,
        input  kbd_read_enable, evt_valid, evt_code, evt_ext, evt_release, evt_ascii, evt_mods
    );
endinterface

// File: rtl/ps2_ascii_lut.sv
// Combinational set-2 scancode to ASCII ROM; returns 0x00 for non-printable keys.
module ps2_ascii_lut
    import ps2_kbd_pkg::*;
(
    input  logic       ext,
    input  logic       shift,
    input  logic       caps,
    input  logic [7:0] code,
    output logic [7:0] ascii
);

    logic [7:0] lo;
    logic [7:0] hi;
    logic       letter;

    always_comb begin
        lo = 8'h00;
        hi = 8'h00;
        case (code)
            8'h1C: lo = "a";  8'h32: lo = "b";  8'h21: lo = "c";  8'h23: lo = "d";
            8'h24: lo = "e";  8'h2B: lo = "f";  8'h34: lo = "g";  8'h33: lo = "h";
            8'h43: lo = "i";  8'h3B: lo = "j";  8'h42: lo = "k";  8'h4B: lo = "l";
            8'h3A: lo = "m";  8'h31: lo = "n";  8'h44: lo = "o";  8'h4D: lo = "p";
            8'h15: lo = "q";  8'h2D: lo = "r";  8'h1B: lo = "s";  8'h2C: lo = "t";
            8'h3C: lo = "u";  8'h2A: lo = "v";  8'h1D: lo = "w";  8'h22: lo = "x";
            8'h35: lo = "y";  8'h1A: lo = "z";
            8'h16: begin lo = "1"; hi = "!"; end
            8'h1E: begin lo = "2"; hi = "@"; end
            8'h26: begin lo = "3"; hi = "#"; end
            8'h25: begin lo = "4"; hi = "$"; end
            8'h2E: begin lo = "5"; hi = "%"; end
            8'h36: begin lo = "6"; hi = "^"; end
            8'h3D: begin lo = "7"; hi = "&"; end
            8'h3E: begin lo = "8"; hi = "*"; end
            8'h46: begin lo = "9"; hi = "("; end
            8'h45: begin lo = "0"; hi = ")"; end
            8'h0E: begin lo = 8'h60; hi = "~"; end
            8'h4E: begin lo = "-"; hi = "_"; end
            8'h55: begin lo = "="; hi = "+"; end
            8'h5D: begin lo = 8'h5C; hi = "|"; end
            8'h54: begin lo = "["; hi = "{"; end
            8'h5B: begin lo = "]"; hi = "}"; end
            8'h4C: begin lo = ";"; hi = ":"; end
            8'h52: begin lo = 8'h27; hi = 8'h22; end
            8'h41: begin lo = ","; hi = "<"; end
            8'h49: begin lo = "."; hi = ">"; end
            8'h4A: begin lo = "/"; hi = "?"; end
            8'h29: begin lo = " "; hi = " "; end
            8'h5A: begin lo = 8'h0D; hi = 8'h0D; end
            8'h66: begin lo = 8'h08; hi = 8'h08; end
            8'h76: begin lo = 8'h1B; hi = 8'h1B; end
            default: ;
        endcase
        letter = (lo >= "a") && (lo <= "z");
        if (letter) hi = lo - 8'h20;
    end

    always_comb begin
        ascii = 8'h00;
        if (!ext) begin
            // Caps only affects letters; it inverts shift rather than forcing upper case.
            if (letter) ascii = (shift ^ caps) ? hi : lo;
            else        ascii = shift ? hi : lo;
        end else if (code == SC_KP_SLASH) begin
            ascii = "/";
        end else if (code == SC_ENTER) begin
            ascii = 8'h0D;
        end
    end

endmodule

// File: rtl/ps2_scancode_decoder.sv
// PS/2 set-2 byte stream to key events with modifier tracking and ASCII translation.
// Define PS2_BREAK_EVENTS_EN to emit break (release) events; otherwise breaks only update state.
module ps2_scancode_decoder
    import ps2_kbd_pkg::*;
#(
    parameter int unsigned PREFIX_TIMEOUT = 1_000_000,
    parameter int unsigned TO_W           = 20
) (
    input logic                   clk,
    input logic                   rst,
    ps2_scancode_decoder_if.master bus
);

    state_e state_q, state_d;
    logic   pop;

    logic [7:0]    byte_q;
    logic          ext_q, ext_d, brk_q, brk_d;
    logic [TO_W-1:0] cnt_q, cnt_d;
    logic          lshift_q, lshift_d, rshift_q, rshift_d;
    logic          lctrl_q, lctrl_d, rctrl_q, rctrl_d;
    logic          caps_q, caps_d, caps_held_q, caps_held_d;

    logic          evt_valid_q, evt_valid_d;
    logic [7:0]    evt_code_q, evt_code_d, evt_ascii_q, evt_ascii_d;
    logic          evt_ext_q, evt_ext_d, evt_rel_q, evt_rel_d;
    logic [2:0]    evt_mods_q, evt_mods_d;

    logic          decoding, is_prefix, fake_shift, key_ev, make, emit, rel_in;
    logic [2:0]    mods_n;
    logic [7:0]    ascii;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= StIdle;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (pop) state_d = StDecode;
            StDecode: state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_comb begin
        pop = (state_q == StIdle) && !rst && bus.kbd_ready && (!evt_valid_q || bus.evt_ready);
    end

    assign bus.kbd_read_enable = pop;

    assign decoding   = (state_q == StDecode);
    assign is_prefix  = (byte_q == SC_EXT) || (byte_q == SC_BRK);
    assign fake_shift = ext_q && ((byte_q == SC_LSHIFT) || (byte_q == SC_RSHIFT));
    assign key_ev     = decoding && !is_prefix && !is_discard(byte_q) && !fake_shift;
    assign make       = !brk_q;

`ifdef PS2_BREAK_EVENTS_EN
    assign emit   = key_ev;
    assign rel_in = brk_q;
`else
    assign emit   = key_ev && make;
    assign rel_in = 1'b0;
`endif

    always_comb begin
        lshift_d    = lshift_q;
        rshift_d    = rshift_q;
        lctrl_d     = lctrl_q;
        rctrl_d     = rctrl_q;
        caps_d      = caps_q;
        caps_held_d = caps_held_q;
        if (key_ev) begin
            if (!ext_q && byte_q == SC_LSHIFT) lshift_d = make;
            if (!ext_q && byte_q == SC_RSHIFT) rshift_d = make;
            if (byte_q == SC_CTRL) begin
                if (ext_q) rctrl_d = make;
                else       lctrl_d = make;
            end
            // caps_held suppresses toggling on typematic repeats of the caps make code.
            if (!ext_q && byte_q == SC_CAPS) begin
                if (make && !caps_held_q) caps_d = !caps_q;
                caps_held_d = make;
            end
        end
        mods_n            = 3'b000;
        mods_n[MOD_SHIFT] = lshift_d | rshift_d;
        mods_n[MOD_CTRL]  = lctrl_d | rctrl_d;
        mods_n[MOD_CAPS]  = caps_d;
    end

    ps2_ascii_lut u_lut (
        .ext   (ext_q),
        .shift (mods_n[MOD_SHIFT]),
        .caps  (mods_n[MOD_CAPS]),
        .code  (byte_q),
        .ascii (ascii)
    );

    always_comb begin
        ext_d = ext_q;
        brk_d = brk_q;
        cnt_d = cnt_q;
        if (ext_q || brk_q) begin
            if (cnt_q == TO_W'(PREFIX_TIMEOUT - 1)) begin
                ext_d = 1'b0;
                brk_d = 1'b0;
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        if (decoding && is_prefix) begin
            if (byte_q == SC_EXT) ext_d = 1'b1;
            else                  brk_d = 1'b1;
            cnt_d = '0;
        end else if (key_ev || (decoding && fake_shift)) begin
            ext_d = 1'b0;
            brk_d = 1'b0;
            cnt_d = '0;
        end
    end

    always_comb begin
        evt_valid_d = evt_valid_q;
        evt_code_d  = evt_code_q;
        evt_ascii_d = evt_ascii_q;
        evt_ext_d   = evt_ext_q;
        evt_rel_d   = evt_rel_q;
        evt_mods_d  = evt_mods_q;
        if (emit) begin
            evt_valid_d = 1'b1;
            evt_code_d  = byte_q;
            evt_ascii_d = ascii;
            evt_ext_d   = ext_q;
            evt_rel_d   = rel_in;
            evt_mods_d  = mods_n;
        end else if (evt_valid_q && bus.evt_ready) begin
            evt_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            byte_q      <= 8'h00;
            ext_q       <= 1'b0;
            brk_q       <= 1'b0;
            cnt_q       <= '0;
            lshift_q    <= 1'b0;
            rshift_q    <= 1'b0;
            lctrl_q     <= 1'b0;
            rctrl_q     <= 1'b0;
            caps_q      <= 1'b0;
            caps_held_q <= 1'b0;
            evt_valid_q <= 1'b0;
            evt_code_q  <= 8'h00;
            evt_ascii_q <= 8'h00;
            evt_ext_q   <= 1'b0;
            evt_rel_q   <= 1'b0;
            evt_mods_q  <= 3'b000;
        end else begin
            if (pop) byte_q <= bus.kbd_data;
            ext_q       <= ext_d;
            brk_q       <= brk_d;
            cnt_q       <= cnt_d;
            lshift_q    <= lshift_d;
            rshift_q    <= rshift_d;
            lctrl_q     <= lctrl_d;
            rctrl_q     <= rctrl_d;
            caps_q      <= caps_d;
            caps_held_q <= caps_held_d;
            evt_valid_q <= evt_valid_d;
            evt_code_q  <= evt_code_d;
            evt_ascii_q <= evt_ascii_d;
            evt_ext_q   <= evt_ext_d;
            evt_rel_q   <= evt_rel_d;
            evt_mods_q  <= evt_mods_d;
        end
    end

    assign bus.evt_valid   = evt_valid_q;
    assign bus.evt_code    = evt_code_q;
    assign bus.evt_ascii   = evt_ascii_q;
    assign bus.evt_ext     = evt_ext_q;
    assign bus.evt_release = evt_rel_q;
    assign bus.evt_mods    = evt_mods_q;

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// Directed bench for ps2_scancode_decoder with a model receiver FIFO and a short prefix timeout.
module tb_ps2_scancode_decoder;

    localparam int unsigned TIMEOUT = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;

    logic [7:0] mem [0:63];
    int         rd_ptr = 0;
    int         wr_ptr = 0;

    ps2_scancode_decoder_if bus ();

    ps2_scancode_decoder #(
        .PREFIX_TIMEOUT (TIMEOUT),
        .TO_W           (20)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    assign bus.kbd_ready = (rd_ptr != wr_ptr);
    assign bus.kbd_data  = mem[rd_ptr[5:0]];

    always @(posedge clk) begin
        if (bus.kbd_read_enable && bus.kbd_ready) rd_ptr <= rd_ptr + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] b);
        mem[wr_ptr[5:0]] = b;
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic expect_event(input string tag, input logic [7:0] code, input logic ext,
                                input logic rel, input logic [7:0] asc, input logic [2:0] mods);
        int n = 0;
        while (bus.evt_valid !== 1'b1 && n < 64) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_valid"}, 32'(bus.evt_valid), 32'd1);
        check({tag, "_code"}, 32'(bus.evt_code), 32'(code));
        check({tag, "_ext"}, 32'(bus.evt_ext), 32'(ext));
        check({tag, "_rel"}, 32'(bus.evt_release), 32'(rel));
        check({tag, "_ascii"}, 32'(bus.evt_ascii), 32'(asc));
        check({tag, "_mods"}, 32'(bus.evt_mods), 32'(mods));
        bus.evt_ready = 1'b1;
        @(negedge clk);
        bus.evt_ready = 1'b0;
    endtask

    task automatic expect_quiet(input string tag, input int cycles);
        repeat (cycles) @(negedge clk);
        check(tag, 32'(bus.evt_valid), 32'd0);
    endtask

    initial begin
        bus.evt_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_valid", 32'(bus.evt_valid), 32'd0);
        check("rst_rden", 32'(bus.kbd_read_enable), 32'd0);
        check("rst_code", 32'(bus.evt_code), 32'd0);
        check("rst_ascii", 32'(bus.evt_ascii), 32'd0);
        check("rst_mods", 32'(bus.evt_mods), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Latency: pop on the next edge, event visible after the following edge.
        push(8'h1C);
        #1 check("lat_rden", 32'(bus.kbd_read_enable), 32'd1);
        @(negedge clk);
        check("lat_decode_rden", 32'(bus.kbd_read_enable), 32'd0);
        check("lat_decode_valid", 32'(bus.evt_valid), 32'd0);
        @(negedge clk);
        check("lat_valid", 32'(bus.evt_valid), 32'd1);
        expect_event("a", 8'h1C, 1'b0, 1'b0, 8'h61, 3'b000);

        // Shift.
        push(8'h12);
        expect_event("lshift", 8'h12, 1'b0, 1'b0, 8'h00, 3'b001);
        push(8'h1C);
        expect_event("A_shift", 8'h1C, 1'b0, 1'b0, 8'h41, 3'b001);
        push(8'hF0); push(8'h12); push(8'h1C);
`ifdef PS2_BREAK_EVENTS_EN
        expect_event("lshift_brk", 8'h12, 1'b0, 1'b1, 8'h00, 3'b000);
`endif
        expect_event("a_unshift", 8'h1C, 1'b0, 1'b0, 8'h61, 3'b000);

        // Caps with typematic repeats.
        push(8'h58);
        expect_event("caps1", 8'h58, 1'b0, 1'b0, 8'h00, 3'b100);
        push(8'h58); push(8'h58);
        expect_event("caps2", 8'h58, 1'b0, 1'b0, 8'h00, 3'b100);
        expect_event("caps3", 8'h58, 1'b0, 1'b0, 8'h00, 3'b100);
        push(8'hF0); push(8'h58); push(8'h1C);
`ifdef PS2_BREAK_EVENTS_EN
        expect_event("caps_brk", 8'h58, 1'b0, 1'b1, 8'h00, 3'b100);
`endif
        expect_event("A_caps", 8'h1C, 1'b0, 1'b0, 8'h41, 3'b100);
        push(8'h58); push(8'hF0); push(8'h58);
        expect_event("caps_off", 8'h58, 1'b0, 1'b0, 8'h00, 3'b000);
`ifdef PS2_BREAK_EVENTS_EN
        expect_event("caps_off_brk", 8'h58, 1'b0, 1'b1, 8'h00, 3'b000);
`endif

        // Extended codes.
        push(8'hE0); push(8'hF0); push(8'h75);
`ifdef PS2_BREAK_EVENTS_EN
        expect_event("up_brk", 8'h75, 1'b1, 1'b1, 8'h00, 3'b000);
`else
        expect_quiet("up_brk_quiet", 12);
`endif
        push(8'hE0); push(8'h5A);
        expect_event("kp_enter", 8'h5A, 1'b1, 1'b0, 8'h0D, 3'b000);
        push(8'hE0); push(8'h4A);
        expect_event("kp_slash", 8'h4A, 1'b1, 1'b0, 8'h2F, 3'b000);

        // Ctrl, discards, fake shift, specials and shifted glyphs.
        push(8'h14); push(8'hF0); push(8'h14);
        expect_event("ctrl", 8'h14, 1'b0, 1'b0, 8'h00, 3'b010);
`ifdef PS2_BREAK_EVENTS_EN
        expect_event("ctrl_brk", 8'h14, 1'b0, 1'b1, 8'h00, 3'b000);
`endif
        push(8'hAA); push(8'hFA); push(8'hE0); push(8'hEE); push(8'h1C);
        expect_event("disc_keeps_ext", 8'h1C, 1'b1, 1'b0, 8'h00, 3'b000);
        push(8'hE0); push(8'h12); push(8'h1C);
        expect_event("fake_shift", 8'h1C, 1'b0, 1'b0, 8'h61, 3'b000);
        push(8'h66);
        expect_event("bksp", 8'h66, 1'b0, 1'b0, 8'h08, 3'b000);
        push(8'h76);
        expect_event("esc", 8'h76, 1'b0, 1'b0, 8'h1B, 3'b000);
        push(8'h59); push(8'h16);
        expect_event("rshift", 8'h59, 1'b0, 1'b0, 8'h00, 3'b001);
        expect_event("bang", 8'h16, 1'b0, 1'b0, 8'h21, 3'b001);
        push(8'hF0); push(8'h59); push(8'h16);
`ifdef PS2_BREAK_EVENTS_EN
        expect_event("rshift_brk", 8'h59, 1'b0, 1'b1, 8'h00, 3'b000);
`endif
        expect_event("one", 8'h16, 1'b0, 1'b0, 8'h31, 3'b000);

        // Backpressure: first event held, no pops until accepted.
        push(8'h1C); push(8'h32); push(8'h21);
        repeat (8) @(negedge clk);
        check("bp_valid", 32'(bus.evt_valid), 32'd1);
        check("bp_code", 32'(bus.evt_code), 32'h1C);
        check("bp_rden", 32'(bus.kbd_read_enable), 32'd0);
        check("bp_fifo", 32'(wr_ptr - rd_ptr), 32'd2);
        expect_event("bp_a", 8'h1C, 1'b0, 1'b0, 8'h61, 3'b000);
        expect_event("bp_b", 8'h32, 1'b0, 1'b0, 8'h62, 3'b000);
        expect_event("bp_c", 8'h21, 1'b0, 1'b0, 8'h63, 3'b000);

        // Prefix timeout: short gap keeps E0, long gap drops it.
        push(8'hE0);
        repeat (4) @(negedge clk);
        push(8'h1C);
        expect_event("to_short", 8'h1C, 1'b1, 1'b0, 8'h00, 3'b000);
        push(8'hE0);
        repeat (TIMEOUT + 8) @(negedge clk);
        push(8'h1C);
        expect_event("to_long", 8'h1C, 1'b0, 1'b0, 8'h61, 3'b000);
        push(8'hF0); push(8'h1C);
`ifdef PS2_BREAK_EVENTS_EN
        expect_event("brk_a", 8'h1C, 1'b0, 1'b1, 8'h61, 3'b000);
`else
        expect_quiet("brk_a_quiet", 12);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
